// File: rtl/dp_result_fifo_pkg.sv
// Shared constants for the datapath result capture stage.
// Holds the datapath output width, the datapath latency and the width helper for the occupancy count.
package dp_result_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DP_LATENCY     = 2;

  // Bits needed to hold an occupancy value from 0 to depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dp_result_fifo_valid_delay.sv
// Shift register that delays the input-side valid by the datapath latency.
// The output marks the cycle in which the datapath's x/z hold that operand set's result.
module valid_delay_line #(
  parameter int LATENCY = 2
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic [LATENCY-1:0] stage;
  // Concatenating d below the stages lets the same shift work when LATENCY is 1.
  logic [LATENCY:0]   shifted;

  assign shifted = {stage, d};
  assign q       = stage[LATENCY-1];

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      stage <= '0;
    end else begin
      stage <= shifted[LATENCY-1:0];
    end
  end

endmodule

// File: rtl/dp_result_fifo.sv
// Capture FIFO for aligned datapath (x, z) results, with overflow flag and drop counter.
// Handshake: a pair transfers on any edge where out_valid && out_ready; out_valid never depends on out_ready.
module dp_result_fifo
  import dp_result_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4,
  parameter int LATENCY    = DP_LATENCY,
  parameter int CNT_W      = 8
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         x,
  input  logic [DATA_WIDTH-1:0]         z,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_x,
  output logic [DATA_WIDTH-1:0]         out_z,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [2*DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           cnt;
  logic                    push_en;
  logic                    pop;
  logic                    accept;
  logic                    drop;

  valid_delay_line #(
    .LATENCY (LATENCY)
  ) u_valid_delay (
    .Clk   (Clk),
    .Rst   (Rst),
    .clear (1'b0),
    .d     (in_valid),
    .q     (push_en)
  );

  assign pop    = out_valid && out_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign accept = push_en && (!full || pop);
  assign drop   = push_en && full && !pop;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {x, z};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (accept && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !accept) begin
        cnt <= cnt - CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + CNT_W'(1);
        end
      end
    end
  end

  assign count          = cnt;
  assign empty          = (cnt == '0);
  assign full           = (cnt == CW'(DEPTH));
  assign out_valid      = !empty;
  assign {out_x, out_z} = mem[rd_ptr];

endmodule

// File: tb/tb_dp_result_fifo.sv
// Self-checking bench for dp_result_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model of the capture stage.
module tb_dp_result_fifo;

  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;
  localparam int CNT_W   = 8;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int SAT     = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            Rst;
  logic            in_valid;
  logic [DW-1:0]   x;
  logic [DW-1:0]   z;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_x;
  logic [DW-1:0]   out_z;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            overflow;
  logic [CNT_W-1:0] drop_count;

  dp_result_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .LATENCY    (LATENCY),
    .CNT_W      (CNT_W)
  ) dut (
    .Clk        (clk),
    .Rst        (Rst),
    .in_valid   (in_valid),
    .x          (x),
    .z          (z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_z      (out_z),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: pending push cycles, the stored pairs, and the drop state.
  int               cyc;
  int               due_q[$];
  logic [2*DW-1:0]  exp_q[$];
  int               m_drops;
  bit               m_ovf;

  int checks   = 0;
  int failures = 0;

  // Scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit iv, input logic [DW-1:0] xv,
                            input logic [DW-1:0] zv, input bit rdy);
    bit push;
    bit pop;
    if (r) begin
      due_q.delete();
      exp_q.delete();
      m_drops = 0;
      m_ovf   = 0;
      return;
    end
    push = (due_q.size() > 0) && (due_q[0] == cyc);
    if (push) void'(due_q.pop_front());
    if (iv) due_q.push_back(cyc + LATENCY);
    pop = rdy && (exp_q.size() > 0);
    if (push && (exp_q.size() == DEPTH) && !pop) begin
      m_ovf = 1;
      if (m_drops < SAT) m_drops++;
    end else if (push) begin
      exp_q.push_back({xv, zv});
    end
    if (pop) void'(exp_q.pop_front());
  endtask

  task automatic compare_all();
    logic [2*DW-1:0] head;
    check("out_valid",  out_valid,  exp_q.size() > 0);
    check("count",      count,      exp_q.size());
    check("full",       full,       exp_q.size() == DEPTH);
    check("empty",      empty,      exp_q.size() == 0);
    check("overflow",   overflow,   m_ovf);
    check("drop_count", drop_count, m_drops);
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      check("out_x", out_x, head[2*DW-1:DW]);
      check("out_z", out_z, head[DW-1:0]);
    end
  endtask

  // Driver: entered just after a negedge; applies inputs, lets one edge pass, checks.
  task automatic step(input bit r, input bit iv, input logic [DW-1:0] xv,
                      input logic [DW-1:0] zv, input bit rdy);
    Rst = r; in_valid = iv; x = xv; z = zv; out_ready = rdy;
    @(posedge clk);
    model_edge(r, iv, xv, zv, rdy);
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [DW-1:0] rnd();
    return $urandom;
  endfunction

  logic [DW-1:0] hold_x;
  logic [DW-1:0] hold_z;

  initial begin
    cyc = 0; m_drops = 0; m_ovf = 0;
    Rst = 1'b1; in_valid = 1'b0; x = '0; z = '0; out_ready = 1'b0;
    @(negedge clk);
    step(1, 0, rnd(), rnd(), 0);
    step(1, 0, rnd(), rnd(), 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_z", out_z, 0);

    // 1: single result
    step(0, 1, rnd(), rnd(), 1);
    step(0, 0, rnd(), rnd(), 1);
    step(0, 0, 32'h11, 32'h22, 1);
    check("t1_valid", out_valid, 1);
    check("t1_x", out_x, 32'h11);
    check("t1_z", out_z, 32'h22);
    step(0, 0, rnd(), rnd(), 1);
    check("t1_drained", {out_valid, count}, 0);

    // 2: fill to full, then drain with stalls while watching the head stay put
    for (int k = 0; k < 6; k++)
      step(0, k < 4, (k >= 2) ? DW'(k - 1) : rnd(), (k >= 2) ? DW'(k + 14) : rnd(), 0);
    check("t2_full", full, 1);
    check("t2_count", count, DEPTH);
    for (int k = 0; k < 10; k++) begin
      hold_x = out_x; hold_z = out_z;
      step(0, 0, rnd(), rnd(), 0);
      if (exp_q.size() > 0) begin
        check("t2_hold_x", out_x, hold_x);
        check("t2_hold_z", out_z, hold_z);
      end
      step(0, 0, rnd(), rnd(), 1);
    end
    check("t2_empty", empty, 1);

    // 3: fill, then two results arrive while stalled
    for (int k = 0; k < 8; k++)
      step(0, k < 6, rnd(), rnd(), 0);
    check("t3_overflow", overflow, 1);
    check("t3_drops", drop_count, 2);
    check("t3_count", count, DEPTH);

    // 4: full, push and pop on the same edge
    step(0, 1, rnd(), rnd(), 0);
    step(0, 0, rnd(), rnd(), 0);
    step(0, 0, 32'h5, 32'h55, 1);
    check("t4_count", count, DEPTH);
    check("t4_drops", drop_count, 2);
    for (int k = 0; k < 6; k++) begin
      if (exp_q.size() == 1) check("t4_last_x", out_x, 32'h5);
      step(0, 0, rnd(), rnd(), 1);
    end

    // 5: long stream across wraps, then a long stall to saturate the drop counter
    for (int k = 0; k < 300; k++)
      step(0, 1, rnd(), rnd(), k[0]);
    for (int k = 0; k < 300; k++)
      step(0, 1, rnd(), rnd(), 0);
    check("t5_sat", drop_count, SAT);
    for (int k = 0; k < 8; k++)
      step(0, 0, rnd(), rnd(), 1);

    // 6: reset while a result is in flight
    step(1, 0, rnd(), rnd(), 0);
    step(0, 1, rnd(), rnd(), 1);
    step(1, 0, rnd(), rnd(), 1);
    step(0, 0, rnd(), rnd(), 1);
    step(0, 0, rnd(), rnd(), 1);
    check("t6_count", count, 0);
    check("t6_valid", out_valid, 0);
    check("t6_ovf", overflow, 0);

    // Random traffic with occasional resets
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, rnd(), rnd(),
           $urandom_range(0, 1) == 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
